dram_tag_lookup: RTL and testbench

//  N-way successor of the single-way tag compare stage of the DRAM cache controller.

---
 rtl/dram_tag_lookup.sv | 187 ++++++++++++++++++
 tb/tb_dram_tag_lookup.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_tag_lookup.sv
// dram_tag_lookup
//   N-way tag compare stage of the DRAM cache controller. It pairs one pending
//   request {rw, id, addr} from the tag FIFO with one tag/data set returned by
//   the memory controller. It compares every way in parallel and registers a
//   single classified result (read/write x hit/miss). The result carries the
//   hit way, or the victim way on a miss, together with that way's data.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid_i/ready_o request slot handshake, req_data_i = {rw, id, addr}
//   rvalid_i/rready_o   response slot handshake
//   rtag_i              per way {valid, tag}, way 0 in the LSBs
//   rdata_i             per way data, way 0 in the LSBs
//   res_valid_o/ready_i result handshake
//   res_kind_o          00 rd-hit, 01 rd-miss, 10 wr-hit, 11 wr-miss
//   res_id_o/addr_o     request id and address
//   res_way_o/data_o    selected way and its data
//   multi_hit_o         sticky flag: more than one way matched
//   hit_cnt_o/miss_cnt_o saturating statistics
`timescale 1ns/1ps
module dram_tag_lookup #(
  parameter int ADDR_WIDTH   = 64,
  parameter int ID_WIDTH     = 16,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 4,
  parameter int TAG_WIDTH    = 56,
  parameter int DATA_WIDTH   = 72,
  parameter int WAYS         = 2,
  parameter int CNT_WIDTH    = 32,
  localparam int WAY_W       = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [ID_WIDTH+ADDR_WIDTH:0]   req_data_i,
  input  logic                           rvalid_i,
  output logic                           rready_o,
  input  logic [WAYS*(TAG_WIDTH+1)-1:0]  rtag_i,
  input  logic [WAYS*DATA_WIDTH-1:0]     rdata_i,
  output logic                           res_valid_o,
  input  logic                           res_ready_i,
  output logic [1:0]                     res_kind_o,
  output logic [ID_WIDTH-1:0]            res_id_o,
  output logic [ADDR_WIDTH-1:0]          res_addr_o,
  output logic [WAY_W-1:0]               res_way_o,
  output logic [DATA_WIDTH-1:0]          res_data_o,
  output logic                           multi_hit_o,
  output logic [CNT_WIDTH-1:0]           hit_cnt_o,
  output logic [CNT_WIDTH-1:0]           miss_cnt_o
);
  localparam int TE_W    = TAG_WIDTH + 1;
  localparam int TAG_LSB = OFFSET_WIDTH + INDEX_WIDTH;

  // Input slots
  logic                        req_full_reg, rsp_full_reg;
  logic                        req_rw_reg;
  logic [ID_WIDTH-1:0]         req_id_reg;
  logic [ADDR_WIDTH-1:0]       req_addr_reg;
  logic [WAYS*TE_W-1:0]        rsp_tag_reg;
  logic [WAYS*DATA_WIDTH-1:0]  rsp_data_reg;

  // Result register and state
  logic                        res_valid_reg;
  logic [1:0]                  res_kind_reg;
  logic [ID_WIDTH-1:0]         res_id_reg;
  logic [ADDR_WIDTH-1:0]       res_addr_reg;
  logic [WAY_W-1:0]            res_way_reg;
  logic [DATA_WIDTH-1:0]       res_data_reg;
  logic                        res_rr_reg;     // result is an all-valid miss
  logic                        multi_hit_reg;
  logic [WAY_W-1:0]            ptr_reg;
  logic [CNT_WIDTH-1:0]        hit_cnt_reg, miss_cnt_reg;

  // Per-way compare
  logic [TAG_WIDTH-1:0]        req_tag;
  logic [WAYS-1:0]             way_valid, hit_vec;
  logic [DATA_WIDTH-1:0]       way_data [WAYS];

  assign req_tag = req_addr_reg[TAG_LSB +: TAG_WIDTH];

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_valid[gi] = rsp_tag_reg[gi*TE_W + TAG_WIDTH];
      assign hit_vec[gi]   = way_valid[gi] &&
                             (rsp_tag_reg[gi*TE_W +: TAG_WIDTH] == req_tag);
      assign way_data[gi]  = rsp_data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic             any_hit, all_valid, multi, fire, handoff;
  logic [WAY_W-1:0] hit_way, inv_way, sel_way;

  // Descending scans leave the lowest matching index in hit_way / inv_way.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w])    hit_way = WAY_W'(w);
      if (!way_valid[w]) inv_way = WAY_W'(w);
    end
  end

  assign any_hit   = |hit_vec;
  assign all_valid = &way_valid;
  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign multi     = |(hit_vec & (hit_vec - WAYS'(1)));
  assign sel_way   = any_hit ? hit_way : (all_valid ? ptr_reg : inv_way);

  assign fire    = req_full_reg && rsp_full_reg && (!res_valid_reg || res_ready_i);
  assign handoff = res_valid_reg && res_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_full_reg  <= 1'b0;
      rsp_full_reg  <= 1'b0;
      req_rw_reg    <= 1'b0;
      req_id_reg    <= '0;
      req_addr_reg  <= '0;
      rsp_tag_reg   <= '0;
      rsp_data_reg  <= '0;
      res_valid_reg <= 1'b0;
      res_kind_reg  <= '0;
      res_id_reg    <= '0;
      res_addr_reg  <= '0;
      res_way_reg   <= '0;
      res_data_reg  <= '0;
      res_rr_reg    <= 1'b0;
      multi_hit_reg <= 1'b0;
      ptr_reg       <= '0;
      hit_cnt_reg   <= '0;
      miss_cnt_reg  <= '0;
    end else begin
      // A full slot is never ready, so it can only be cleared, not refilled, on fire.
      if (fire) begin
        req_full_reg <= 1'b0;
      end else if (req_valid_i && !req_full_reg) begin
        req_full_reg <= 1'b1;
        {req_rw_reg, req_id_reg, req_addr_reg} <= req_data_i;
      end

      if (fire) begin
        rsp_full_reg <= 1'b0;
      end else if (rvalid_i && !rsp_full_reg) begin
        rsp_full_reg <= 1'b1;
        rsp_tag_reg  <= rtag_i;
        rsp_data_reg <= rdata_i;
      end

      if (fire) begin
        res_valid_reg <= 1'b1;
        res_kind_reg  <= {req_rw_reg, !any_hit};
        res_id_reg    <= req_id_reg;
        res_addr_reg  <= req_addr_reg;
        res_way_reg   <= sel_way;
        res_data_reg  <= way_data[sel_way];
        res_rr_reg    <= !any_hit && all_valid;
        if (multi) multi_hit_reg <= 1'b1;
      end else if (handoff) begin
        res_valid_reg <= 1'b0;
      end

      // Pointer and statistics only move once the consumer has taken the result.
      if (handoff) begin
        if (res_rr_reg)
          ptr_reg <= (ptr_reg == WAY_W'(WAYS - 1)) ? '0 : ptr_reg + WAY_W'(1);
        if (res_kind_reg[0]) begin
          if (miss_cnt_reg != '1) miss_cnt_reg <= miss_cnt_reg + CNT_WIDTH'(1);
        end else begin
          if (hit_cnt_reg != '1) hit_cnt_reg <= hit_cnt_reg + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign req_ready_o = !req_full_reg;
  assign rready_o    = !rsp_full_reg;
  assign res_valid_o = res_valid_reg;
  assign res_kind_o  = res_kind_reg;
  assign res_id_o    = res_id_reg;
  assign res_addr_o  = res_addr_reg;
  assign res_way_o   = res_way_reg;
  assign res_data_o  = res_data_reg;
  assign multi_hit_o = multi_hit_reg;
  assign hit_cnt_o   = hit_cnt_reg;
  assign miss_cnt_o  = miss_cnt_reg;
endmodule

// File: tb/tb_dram_tag_lookup.sv
// tb_dram_tag_lookup
//   Self-checking bench for dram_tag_lookup (WAYS=2, 4-bit counters so that
//   saturation is reachable). Expected results come from a behavioural model
//   that classifies each request/response pair from the cache rules directly.
`timescale 1ns/1ps
module tb_dram_tag_lookup;
  localparam int AW = 64, IW = 16, TW = 56, DW = 72, CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, req_valid_i, req_ready_o, rvalid_i, rready_o;
  logic [IW+AW:0]    req_data_i;
  logic [2*(TW+1)-1:0] rtag_i;
  logic [2*DW-1:0]   rdata_i;
  logic              res_valid_o, res_ready_i, multi_hit_o;
  logic [1:0]        res_kind_o;
  logic [IW-1:0]     res_id_o;
  logic [AW-1:0]     res_addr_o;
  logic [0:0]        res_way_o;
  logic [DW-1:0]     res_data_o;
  logic [CW-1:0]     hit_cnt_o, miss_cnt_o;

  // Response contents presented by the memory controller
  logic          vl [2];
  logic [TW-1:0] tg [2];
  logic [DW-1:0] dt [2];
  assign rtag_i  = {vl[1], tg[1], vl[0], tg[0]};
  assign rdata_i = {dt[1], dt[0]};

  dram_tag_lookup #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rtag_i(rtag_i), .rdata_i(rdata_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_kind_o(res_kind_o),
    .res_id_o(res_id_o), .res_addr_o(res_addr_o), .res_way_o(res_way_o),
    .res_data_o(res_data_o), .multi_hit_o(multi_hit_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  int            m_ptr, m_hit, m_miss;
  bit            m_multi;
  logic [1:0]    exp_kind;
  int            exp_way;
  logic [DW-1:0] exp_data;
  bit            exp_rr;

  function automatic void model_reset();
    m_ptr = 0; m_hit = 0; m_miss = 0; m_multi = 0;
  endfunction

  function automatic void model_eval(input bit rw, input logic [AW-1:0] addr);
    logic [TW-1:0] t;
    int hits, first, inv;
    t = TW'(addr / 256);  // drop offset and index (8 bits)
    hits = 0; first = -1; inv = -1;
    for (int w = 0; w < 2; w++) begin
      if (vl[w] && tg[w] == t) begin
        hits++;
        if (first < 0) first = w;
      end
      if (!vl[w] && inv < 0) inv = w;
    end
    if (hits > 0) begin
      exp_kind = {rw, 1'b0}; exp_way = first; exp_rr = 0;
    end else begin
      exp_kind = {rw, 1'b1};
      exp_way  = (inv >= 0) ? inv : m_ptr;
      exp_rr   = (inv < 0);
    end
    exp_data = dt[exp_way];
    if (hits > 1) m_multi = 1;
  endfunction

  function automatic void model_commit(input logic [1:0] kind, input bit rr);
    int lim;
    lim = (1 << CW) - 1;
    if (kind[0]) m_miss = (m_miss < lim) ? m_miss + 1 : lim;
    else         m_hit  = (m_hit  < lim) ? m_hit  + 1 : lim;
    if (rr) m_ptr = (m_ptr + 1) % 2;
  endfunction

  // ---------------- drivers ----------------
  logic [1:0]    obs_kind;
  logic [0:0]    obs_way;
  logic [DW-1:0] obs_data;
  logic [IW-1:0] obs_id;
  logic [AW-1:0] obs_addr;

  function automatic logic [AW-1:0] mk_addr(input logic [TW-1:0] t);
    logic [7:0] lo;
    lo = 8'($urandom);
    return {t, lo};
  endfunction

  function automatic void set_ways(input bit v0, input logic [TW-1:0] t0,
                                   input bit v1, input logic [TW-1:0] t1);
    vl[0] = v0; tg[0] = t0; vl[1] = v1; tg[1] = t1;
    dt[0] = {8'($urandom), $urandom, $urandom};
    dt[1] = {8'($urandom), $urandom, $urandom};
  endfunction

  // Present request and response together; return once both have been taken.
  task automatic send_pair(input bit rw, input logic [IW-1:0] id, input logic [AW-1:0] addr);
    bit rq_acc, rs_acc;
    int n;
    req_data_i = {rw, id, addr};
    req_valid_i = 1'b1; rvalid_i = 1'b1; n = 0;
    while ((req_valid_i || rvalid_i) && n < 20) begin
      rq_acc = req_valid_i && req_ready_o;
      rs_acc = rvalid_i && rready_o;
      @(negedge clk);
      if (rq_acc) req_valid_i = 1'b0;
      if (rs_acc) rvalid_i = 1'b0;
      n++;
    end
    checks++;
    if (req_valid_i || rvalid_i) begin
      failures++;
      $display("FAIL send_pair_timeout req_pending=%0b rsp_pending=%0b required=0/0", req_valid_i, rvalid_i);
      req_valid_i = 1'b0; rvalid_i = 1'b0;
    end
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!res_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!res_valid_o) begin
      failures++;
      $display("FAIL wait_result_timeout res_valid=0 required=1");
    end
    obs_kind = res_kind_o; obs_way = res_way_o; obs_data = res_data_o;
    obs_id = res_id_o; obs_addr = res_addr_o;
  endtask

  // Full transaction with res_ready_i high; returns after the handshake edge.
  task automatic run_pair(input bit rw, input logic [IW-1:0] id, input logic [AW-1:0] addr);
    send_pair(rw, id, addr);
    wait_result();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req_valid_i = 1'b0; rvalid_i = 1'b0; res_ready_i = 1'b1;
    req_data_i = '0; set_ways(0, '0, 0, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    checks++; if (res_valid_o !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid_o); end
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready_o); end
    checks++; if (rready_o !== 1'b1) begin failures++; $display("FAIL reset_rready got=%0b exp=1", rready_o); end
    checks++; if ({res_kind_o, res_way_o, res_id_o, res_addr_o, res_data_o} !== '0) begin failures++; $display("FAIL reset_res_fields got=%0h exp=0", {res_kind_o, res_way_o, res_id_o, res_addr_o, res_data_o}); end
    checks++; if ({multi_hit_o, hit_cnt_o, miss_cnt_o} !== '0) begin failures++; $display("FAIL reset_stats got=%0h exp=0", {multi_hit_o, hit_cnt_o, miss_cnt_o}); end
  endtask

  task automatic test_rd_hit();
    logic [AW-1:0] a;
    set_ways(1, 56'h12, 1, 56'hAB);
    a = mk_addr(56'hAB);
    model_eval(0, a);
    run_pair(0, 16'h1234, a);
    model_commit(exp_kind, exp_rr);
    checks++; if (obs_kind !== exp_kind) begin failures++; $display("FAIL rd_hit_kind got=%0h exp=%0h", obs_kind, exp_kind); end
    checks++; if (obs_way !== exp_way[0]) begin failures++; $display("FAIL rd_hit_way got=%0h exp=%0h", obs_way, exp_way); end
    checks++; if (obs_data !== exp_data) begin failures++; $display("FAIL rd_hit_data got=%0h exp=%0h", obs_data, exp_data); end
    checks++; if (obs_id !== 16'h1234 || obs_addr !== a) begin failures++; $display("FAIL rd_hit_id_addr got=%0h/%0h exp=1234/%0h", obs_id, obs_addr, a); end
    checks++; if (hit_cnt_o !== CW'(m_hit)) begin failures++; $display("FAIL rd_hit_cnt got=%0d exp=%0d", hit_cnt_o, m_hit); end
  endtask

  task automatic test_wr_miss_invalid();
    logic [AW-1:0] a;
    set_ways(0, 56'h55, 1, 56'h77);
    a = mk_addr(56'h55);
    model_eval(1, a);
    run_pair(1, 16'h00AA, a);
    model_commit(exp_kind, exp_rr);
    checks++; if (obs_kind !== exp_kind) begin failures++; $display("FAIL wr_miss_kind got=%0h exp=%0h", obs_kind, exp_kind); end
    checks++; if (obs_way !== exp_way[0]) begin failures++; $display("FAIL wr_miss_way got=%0h exp=%0h", obs_way, exp_way); end
    checks++; if (obs_data !== exp_data) begin failures++; $display("FAIL wr_miss_data got=%0h exp=%0h", obs_data, exp_data); end
    checks++; if (miss_cnt_o !== CW'(m_miss)) begin failures++; $display("FAIL wr_miss_cnt got=%0d exp=%0d", miss_cnt_o, m_miss); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] a;
    for (int i = 0; i < 4; i++) begin
      set_ways(1, 56'h1, 1, 56'h2);
      a = mk_addr(56'h99);
      model_eval(0, a);
      run_pair(0, 16'(i), a);
      model_commit(exp_kind, exp_rr);
      checks++; if (obs_way !== exp_way[0] || obs_kind !== exp_kind) begin failures++; $display("FAIL rr_victim_%0d got=way%0h/kind%0h exp=way%0h/kind%0h", i, obs_way, obs_kind, exp_way, exp_kind); end
      checks++; if (obs_data !== exp_data) begin failures++; $display("FAIL rr_data_%0d got=%0h exp=%0h", i, obs_data, exp_data); end
    end
  endtask

  task automatic test_rsp_first();
    logic [AW-1:0] a;
    set_ways(1, 56'h3C, 1, 56'h4D);
    a = mk_addr(56'h4D);
    model_eval(1, a);
    rvalid_i = 1'b1;
    @(negedge clk);
    rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rready_o !== 1'b0 || res_valid_o !== 1'b0) begin failures++; $display("FAIL rsp_first_wait_%0d got=rready%0b/valid%0b exp=0/0", i, rready_o, res_valid_o); end
      @(negedge clk);
    end
    req_data_i = {1'b1, 16'hBEEF, a};
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    checks++; if (res_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin failures++; $display("FAIL rsp_first_capture got=valid%0b/req_ready%0b exp=0/0", res_valid_o, req_ready_o); end
    @(negedge clk);
    checks++; if (res_valid_o !== 1'b1) begin failures++; $display("FAIL rsp_first_latency got=%0b exp=1", res_valid_o); end
    checks++; if (res_kind_o !== exp_kind || res_way_o !== exp_way[0] || res_data_o !== exp_data) begin failures++; $display("FAIL rsp_first_result got=%0h/%0h/%0h exp=%0h/%0h/%0h", res_kind_o, res_way_o, res_data_o, exp_kind, exp_way, exp_data); end
    @(negedge clk);
    model_commit(exp_kind, exp_rr);
    checks++; if (res_valid_o !== 1'b0 || hit_cnt_o !== CW'(m_hit)) begin failures++; $display("FAIL rsp_first_handoff got=valid%0b/hits%0d exp=0/%0d", res_valid_o, hit_cnt_o, m_hit); end
  endtask

  task automatic test_back_to_back_stall();
    logic [AW-1:0] a, b;
    logic [1:0] a_kind, b_kind;
    logic [DW-1:0] a_data, b_data;
    int b_way;
    bit a_rr, b_rr;
    int hit0, miss0;
    res_ready_i = 1'b0;
    // A: read hit on way 0
    set_ways(1, 56'h21, 1, 56'h22);
    a = mk_addr(56'h21);
    model_eval(0, a);
    a_kind = exp_kind; a_data = exp_data; a_rr = exp_rr;
    send_pair(0, 16'h0A0A, a);
    wait_result();
    // B: write miss, way 1 invalid
    set_ways(1, 56'h31, 0, 56'h32);
    b = mk_addr(56'h33);
    model_eval(1, b);
    b_kind = exp_kind; b_data = exp_data; b_way = exp_way; b_rr = exp_rr;
    send_pair(1, 16'h0B0B, b);
    hit0 = m_hit; miss0 = m_miss;
    for (int i = 0; i < 5; i++) begin
      checks++; if (res_valid_o !== 1'b1 || res_kind_o !== a_kind || res_data_o !== a_data || res_addr_o !== a || res_id_o !== 16'h0A0A) begin failures++; $display("FAIL stall_hold_%0d got=%0b/%0h/%0h exp=1/%0h/%0h", i, res_valid_o, res_kind_o, res_data_o, a_kind, a_data); end
      checks++; if (req_ready_o !== 1'b0 || rready_o !== 1'b0) begin failures++; $display("FAIL stall_ready_%0d got=%0b/%0b exp=0/0", i, req_ready_o, rready_o); end
      checks++; if (hit_cnt_o !== CW'(hit0) || miss_cnt_o !== CW'(miss0)) begin failures++; $display("FAIL stall_cnt_%0d got=%0d/%0d exp=%0d/%0d", i, hit_cnt_o, miss_cnt_o, hit0, miss0); end
      @(negedge clk);
    end
    res_ready_i = 1'b1;
    @(negedge clk);
    model_commit(a_kind, a_rr);
    checks++; if (res_valid_o !== 1'b1 || res_kind_o !== b_kind || res_way_o !== b_way[0] || res_data_o !== b_data || res_id_o !== 16'h0B0B) begin failures++; $display("FAIL b2b_result got=%0b/%0h/%0h/%0h exp=1/%0h/%0h/%0h", res_valid_o, res_kind_o, res_way_o, res_data_o, b_kind, b_way, b_data); end
    checks++; if (hit_cnt_o !== CW'(m_hit)) begin failures++; $display("FAIL b2b_hit_cnt got=%0d exp=%0d", hit_cnt_o, m_hit); end
    @(negedge clk);
    model_commit(b_kind, b_rr);
    checks++; if (res_valid_o !== 1'b0 || miss_cnt_o !== CW'(m_miss)) begin failures++; $display("FAIL b2b_drain got=%0b/%0d exp=0/%0d", res_valid_o, miss_cnt_o, m_miss); end
  endtask

  task automatic test_multi_hit();
    logic [AW-1:0] a;
    set_ways(1, 56'h5A, 1, 56'h5A);
    a = mk_addr(56'h5A);
    model_eval(0, a);
    run_pair(0, 16'h0005, a);
    model_commit(exp_kind, exp_rr);
    checks++; if (obs_way !== exp_way[0] || obs_kind !== exp_kind) begin failures++; $display("FAIL multi_way got=%0h/%0h exp=%0h/%0h", obs_way, obs_kind, exp_way, exp_kind); end
    checks++; if (multi_hit_o !== m_multi) begin failures++; $display("FAIL multi_flag got=%0b exp=%0b", multi_hit_o, m_multi); end
    set_ways(1, 56'h60, 1, 56'h61);
    a = mk_addr(56'h61);
    model_eval(0, a);
    run_pair(0, 16'h0006, a);
    model_commit(exp_kind, exp_rr);
    checks++; if (multi_hit_o !== m_multi || obs_way !== exp_way[0]) begin failures++; $display("FAIL multi_sticky got=%0b/%0h exp=%0b/%0h", multi_hit_o, obs_way, m_multi, exp_way); end
  endtask

  task automatic test_saturation();
    logic [AW-1:0] a;
    for (int i = 0; i < 36; i++) begin
      set_ways(1, 56'h70, 1, 56'h71);
      a = mk_addr((i % 2 == 0) ? 56'h70 : 56'h7F);
      model_eval(1'(i / 2), a);
      run_pair(1'(i / 2), 16'(i), a);
      model_commit(exp_kind, exp_rr);
    end
    checks++; if (hit_cnt_o !== CW'(m_hit)) begin failures++; $display("FAIL sat_hit got=%0d exp=%0d", hit_cnt_o, m_hit); end
    checks++; if (miss_cnt_o !== CW'(m_miss)) begin failures++; $display("FAIL sat_miss got=%0d exp=%0d", miss_cnt_o, m_miss); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [IW-1:0] id;
    bit rw;
    for (int i = 0; i < 60; i++) begin
      set_ways(1'($urandom), 56'(16 + $urandom_range(0, 2)), 1'($urandom), 56'(16 + $urandom_range(0, 2)));
      a  = mk_addr(56'(16 + $urandom_range(0, 3)));
      id = 16'($urandom);
      rw = 1'($urandom);
      model_eval(rw, a);
      run_pair(rw, id, a);
      model_commit(exp_kind, exp_rr);
      checks++; if (obs_kind !== exp_kind || obs_way !== exp_way[0]) begin failures++; $display("FAIL rand_%0d_class got=%0h/%0h exp=%0h/%0h", i, obs_kind, obs_way, exp_kind, exp_way); end
      checks++; if (obs_data !== exp_data || obs_id !== id || obs_addr !== a) begin failures++; $display("FAIL rand_%0d_payload got=%0h/%0h exp=%0h/%0h", i, obs_data, obs_id, exp_data, id); end
      checks++; if (hit_cnt_o !== CW'(m_hit) || miss_cnt_o !== CW'(m_miss) || multi_hit_o !== m_multi) begin failures++; $display("FAIL rand_%0d_stats got=%0d/%0d/%0b exp=%0d/%0d/%0b", i, hit_cnt_o, miss_cnt_o, multi_hit_o, m_hit, m_miss, m_multi); end
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [AW-1:0] a;
    res_ready_i = 1'b0;
    set_ways(1, 56'h5A, 1, 56'h5A);
    send_pair(0, 16'h0101, mk_addr(56'h5A));
    wait_result();
    send_pair(1, 16'h0202, mk_addr(56'h44));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    checks++; if (res_valid_o !== 1'b0 || req_ready_o !== 1'b1 || rready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_hs got=%0b/%0b/%0b exp=0/1/1", res_valid_o, req_ready_o, rready_o); end
    checks++; if ({res_kind_o, res_way_o, res_id_o, res_addr_o, res_data_o} !== '0) begin failures++; $display("FAIL rst_mid_fields got=%0h exp=0", {res_kind_o, res_way_o, res_id_o, res_addr_o, res_data_o}); end
    checks++; if ({multi_hit_o, hit_cnt_o, miss_cnt_o} !== '0) begin failures++; $display("FAIL rst_mid_stats got=%0h exp=0", {multi_hit_o, hit_cnt_o, miss_cnt_o}); end
    // Nothing buffered before reset may surface afterwards.
    res_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (res_valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_discard got=%0b exp=0", res_valid_o); end
    set_ways(1, 56'h1, 1, 56'h2);
    a = mk_addr(56'h9);
    model_eval(0, a);
    run_pair(0, 16'h0303, a);
    model_commit(exp_kind, exp_rr);
    checks++; if (obs_id !== 16'h0303 || obs_way !== exp_way[0] || obs_kind !== exp_kind) begin failures++; $display("FAIL rst_mid_after got=%0h/%0h/%0h exp=0303/%0h/%0h", obs_id, obs_way, obs_kind, exp_way, exp_kind); end
  endtask

  initial begin
    test_reset();
    test_rd_hit();
    test_wr_miss_invalid();
    test_round_robin();
    test_rsp_first();
    test_back_to_back_stall();
    test_multi_hit();
    test_saturation();
    test_random();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
